// File: rtl/gdp_datapath.sv
// GDP summation datapath: 4-entry register file, input mux, ALU, shifter and a
// registered output port. The GDP control unit drives the control word each
// cycle, and this block returns nEqZero so the controller can end its loop.
module gdp_datapath #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          IE,
  input  logic          WE,
  input  logic [1:0]    WA,
  input  logic          RAE,
  input  logic [1:0]    RAA,
  input  logic          RBE,
  input  logic [1:0]    RBA,
  input  logic [2:0]    ALU,
  input  logic [1:0]    SH,
  input  logic          OE,
  input  logic [DW-1:0] in_data,
  output logic          nEqZero,
  output logic [DW-1:0] out_data,
  output logic          out_valid
);

  // ALU operations; all results wrap mod 2^DW, carries and borrows are dropped.
  function automatic logic [DW-1:0] alu_op(input logic [2:0]    op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] r;
    unique case (op)
      3'b000:  r = a;
      3'b001:  r = a & b;
      3'b010:  r = a | b;
      3'b011:  r = ~a;
      3'b100:  r = a + b;
      3'b101:  r = a - b;
      3'b110:  r = a + DW'(1);
      default: r = a - DW'(1);
    endcase
    return r;
  endfunction

  // Shifter: pass, shift left/right by one with zero fill, or rotate right.
  function automatic logic [DW-1:0] shift_op(input logic [1:0]    op,
                                             input logic [DW-1:0] v);
    logic [DW-1:0] r;
    unique case (op)
      2'b00:   r = v;
      2'b01:   r = {v[DW-2:0], 1'b0};
      2'b10:   r = {1'b0, v[DW-1:1]};
      default: r = {v[0], v[DW-1:1]};
    endcase
    return r;
  endfunction

  logic [DW-1:0] rf_p1 [4];
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] sh_res;
  logic [DW-1:0] wb;

  // ---- stage p0: combinational read, compute and write-back select ----
  // A disabled read port drives zero so a stale register never leaks into the ALU.
  assign rd_a    = RAE ? rf_p1[RAA] : '0;
  assign rd_b    = RBE ? rf_p1[RBA] : '0;
  assign alu_res = alu_op(ALU, rd_a, rd_b);
  assign sh_res  = shift_op(SH, alu_res);
  assign wb      = IE ? in_data : sh_res;
  assign nEqZero = (wb == '0);

  // ---- stage p1: register file and output port ----
  // Register file write; a same-cycle read sees the old contents (no bypass).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf_p1[i] <= '0;
    end else if (WE) begin
      rf_p1[WA] <= wb;
    end
  end

  // Output capture takes the shifter result, never in_data, even when IE is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= OE;
      if (OE) out_data <= sh_res;
    end
  end

endmodule

// File: tb/tb_gdp_datapath.sv
// Directed bench for gdp_datapath: hand-computed vectors covering reset,
// read-port gating, every ALU and shifter code, wrap-around, the n..1
// summation sequence, output pulse behaviour and write/read ordering.
module tb_gdp_datapath;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          IE, WE, RAE, RBE, OE;
  logic [1:0]    WA, RAA, RBA, SH;
  logic [2:0]    ALU;
  logic [DW-1:0] in_data;
  logic          nEqZero;
  logic [DW-1:0] out_data;
  logic          out_valid;

  int n_vec = 0;
  int n_bad = 0;

  gdp_datapath #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .IE(IE), .WE(WE), .WA(WA), .RAE(RAE), .RAA(RAA),
    .RBE(RBE), .RBA(RBA), .ALU(ALU), .SH(SH), .OE(OE), .in_data(in_data),
    .nEqZero(nEqZero), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic ie, input logic we, input logic [1:0] wa,
                     input logic rae, input logic [1:0] raa,
                     input logic rbe, input logic [1:0] rba,
                     input logic [2:0] alu, input logic [1:0] sh,
                     input logic oe, input logic [7:0] din);
    IE = ie; WE = we; WA = wa; RAE = rae; RAA = raa; RBE = rbe; RBA = rba;
    ALU = alu; SH = sh; OE = oe; in_data = din;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Capture register raa through ALU op/shift into out_data and check it.
  task automatic cap(input string tag, input logic [1:0] raa, input logic [1:0] rba,
                     input logic [2:0] alu, input logic [1:0] sh, input logic [7:0] exp);
    drv(0, 0, 0, 1, raa, 1, rba, alu, sh, 1, 8'h00);
    tick;
    check_vec(tag, out_data, exp);
  endtask

  initial begin : main
    logic [7:0] exp_r0, exp_r1;
    bit done;

    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h00);
    check_vec("rst_out_data", out_data, 8'h00);
    check_vec("rst_out_valid", out_valid, 1'b0);
    check_vec("rst_nez", nEqZero, 1'b1);
    tick;
    rst = 1'b0;
    tick;

    // Load R1=0x33 and see it through the output port.
    drv(1, 1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h33);
    check_vec("ld33_nez", nEqZero, 1'b0);
    tick;
    cap("rd_r1_33", 1, 0, 3'b000, 2'b00, 8'h33);
    check_vec("rd_r1_valid", out_valid, 1'b1);

    // Asynchronous reset mid-cycle: everything clears before any edge.
    drv(0, 0, 0, 1, 1, 0, 0, 3'b000, 2'b00, 0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check_vec("arst_out_data", out_data, 8'h00);
    check_vec("arst_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 1, 2'(i), 0, 0, 3'b000, 2'b00, 0, 8'h00);
      check_vec($sformatf("arst_r%0d_zero", i), nEqZero, 1'b1);
    end
    @(negedge clk);
    rst = 1'b0;
    tick;

    // Load n=5 into R1, read it back.
    drv(1, 1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h05);
    check_vec("ld5_nez", nEqZero, 1'b0);
    tick;
    cap("rd_r1_5", 1, 0, 3'b000, 2'b00, 8'h05);

    // Summation: put junk in R0, clear it with R0-R0, then loop.
    drv(1, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h5A);
    tick;
    drv(0, 1, 0, 1, 0, 1, 0, 3'b101, 2'b00, 0, 8'h00);
    check_vec("clr_r0_nez", nEqZero, 1'b1);
    tick;
    exp_r0 = 8'h00;
    exp_r1 = 8'h05;
    done = 1'b0;
    for (int it = 0; it < 10 && !done; it++) begin
      drv(0, 1, 0, 1, 0, 1, 1, 3'b100, 2'b00, 0, 8'h00);
      exp_r0 = exp_r0 + exp_r1;
      tick;
      drv(0, 1, 1, 1, 1, 0, 0, 3'b111, 2'b00, 0, 8'h00);
      exp_r1 = exp_r1 - 8'h01;
      check_vec($sformatf("loop%0d_nez", it), nEqZero, exp_r1 == 8'h00);
      done = (exp_r1 == 8'h00);
      tick;
    end
    cap("sum_out", 0, 0, 3'b000, 2'b00, 8'h0F);
    check_vec("sum_valid", out_valid, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h00);
    tick;
    check_vec("sum_valid_drop", out_valid, 1'b0);
    check_vec("sum_hold", out_data, 8'h0F);

    // in_data=0 into R0: zero flag same cycle, R0 reads zero afterwards.
    drv(1, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h00);
    check_vec("in0_nez", nEqZero, 1'b1);
    tick;
    cap("in0_out", 0, 0, 3'b000, 2'b00, 8'h00);

    // Wrap: R0=0xFF, R1=0x01.
    drv(1, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'hFF);
    tick;
    drv(1, 1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h01);
    tick;
    cap("pre_wrap_r0", 0, 0, 3'b000, 2'b00, 8'hFF);
    // R0 <= R0+R1 = 0x00 while capturing the same sum.
    drv(0, 1, 0, 1, 0, 1, 1, 3'b100, 2'b00, 1, 8'h00);
    check_vec("wrap_add_nez", nEqZero, 1'b1);
    tick;
    check_vec("wrap_add_out", out_data, 8'h00);
    drv(0, 0, 0, 1, 0, 0, 0, 3'b111, 2'b00, 1, 8'h00);
    check_vec("wrap_dec_nez", nEqZero, 1'b0);
    tick;
    check_vec("wrap_dec_out", out_data, 8'hFF);

    // Shifter on A=0x81 with OE held across cycles.
    drv(1, 1, 2, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h81);
    tick;
    cap("sh_shl", 2, 0, 3'b000, 2'b01, 8'h02);
    cap("sh_shr", 2, 0, 3'b000, 2'b10, 8'h40);
    check_vec("oe_held_valid", out_valid, 1'b1);
    cap("sh_ror", 2, 0, 3'b000, 2'b11, 8'hC0);
    cap("sh_pass", 2, 0, 3'b000, 2'b00, 8'h81);

    // Disabled read ports drive zero.
    drv(0, 0, 0, 0, 2, 0, 0, 3'b000, 2'b00, 1, 8'h00);
    check_vec("rae0_nez", nEqZero, 1'b1);
    tick;
    check_vec("rae0_out", out_data, 8'h00);
    drv(0, 0, 0, 1, 2, 0, 2, 3'b100, 2'b00, 1, 8'h00);
    tick;
    check_vec("rbe0_add", out_data, 8'h81);

    // Remaining ALU codes with R2=0x81, R3=0x3C.
    drv(1, 1, 3, 0, 0, 0, 0, 3'b000, 2'b00, 0, 8'h3C);
    tick;
    cap("alu_and", 2, 3, 3'b001, 2'b00, 8'h00);
    cap("alu_or", 2, 3, 3'b010, 2'b00, 8'hBD);
    cap("alu_not", 2, 3, 3'b011, 2'b00, 8'h7E);
    cap("alu_sub", 2, 3, 3'b101, 2'b00, 8'h45);
    cap("alu_inc", 2, 3, 3'b110, 2'b00, 8'h82);

    // Write and capture on one edge: capture sees old R3, next read sees new.
    drv(1, 1, 3, 1, 3, 0, 0, 3'b000, 2'b00, 1, 8'h11);
    tick;
    check_vec("nobypass_old", out_data, 8'h3C);
    cap("nobypass_new", 3, 0, 3'b000, 2'b00, 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
